// File: rtl/registerfile_pkg.sv
// Shared types and helpers for the multi-core register file.
package registerfile_pkg;

  // Register 0 is hard-wired to zero in every bank.
  localparam int ZERO_REG = 0;

  // Address width needed to reach DEPTH registers.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // True when addr falls in the top SHARED registers common to all cores.
  function automatic logic is_shared(input int addr, input int depth, input int shared);
    return (shared > 0) && (addr >= depth - shared);
  endfunction

endpackage

// File: rtl/registerfile_mc_if.sv
// Per-core read/write port bundle of the multi-core register file.
interface registerfile_mc_if #(
  parameter int CORES = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  import registerfile_pkg::*;

  localparam int AW = addr_width(DEPTH);

  logic [CORES-1:0]           write_enable;
  logic [CORES-1:0][AW-1:0]    write_address;
  logic [CORES-1:0][WIDTH-1:0] write_data;
  logic [CORES-1:0][AW-1:0]    read_address_1;
  logic [CORES-1:0][AW-1:0]    read_address_2;
  logic [CORES-1:0][WIDTH-1:0] read_data_1;
  logic [CORES-1:0][WIDTH-1:0] read_data_2;
  logic [CORES-1:0]           write_grant;

  // Cores (decode/writeback side) drive requests and observe data and grants.
  modport master (
    output write_enable, write_address, write_data, read_address_1, read_address_2,
    input  read_data_1, read_data_2, write_grant
  );

  // The register file answers requests.
  modport slave (
    input  write_enable, write_address, write_data, read_address_1, read_address_2,
    output read_data_1, read_data_2, write_grant
  );

endinterface

// File: rtl/registerfile_mc_rr_arbiter.sv
// Round-robin arbiter for the single shared-bank write port.
// Search starts at the pointer and wraps; the pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptrReg;
  logic [PW-1:0] ptrNext;
  logic [N-1:0]  grantNext;

  // Pick the first requester at or above the pointer, wrapping at N-1.
  always_comb begin
    logic found;
    int   idx;
    grantNext = '0;
    ptrNext   = ptrReg;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptrReg) + i) % N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grantNext[idx] = 1'b1;
        ptrNext        = PW'((idx + 1) % N);
      end
    end
  end

  // Grants are suppressed while reset is held.
  assign grant = reset_n ? grantNext : '0;

  // Pointer only advances when something was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptrReg <= '0;
    end else begin
      ptrReg <= ptrNext;
    end
  end

endmodule

// File: rtl/registerfile_mc.sv
// Multi-core register file: private bank per core plus a shared window at the
// top of the address space. Two combinational read ports and one write port per
// core; shared writes go through a round-robin arbiter.
// Optional macro REGISTERFILE_BYPASS_EN forwards granted write data to
// same-cycle reads of the same non-zero address.
module registerfile_mc
  import registerfile_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int SHARED = 4
) (
  input logic              clk,
  input logic              reset_n,
  registerfile_mc_if.slave rfBus
);
  localparam int AW          = addr_width(DEPTH);
  localparam int SHARED_BASE = DEPTH - SHARED;
  localparam int SH_N        = (SHARED > 0) ? SHARED : 1;

  logic [CORES-1:0] sharedReq;
  logic [CORES-1:0] sharedGrant;
  logic [CORES-1:0] privWe;

  logic             sharedWe;
  logic [AW-1:0]    sharedWaddr;
  logic [WIDTH-1:0] sharedWdata;
  logic [WIDTH-1:0] sharedBank [SH_N];

  // Shared write arbitration; a single core or no shared window needs no arbiter.
  generate
    if (SHARED > 0 && CORES > 1) begin : genArb
      rr_arbiter #(.N(CORES)) uArb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (sharedReq),
        .grant   (sharedGrant)
      );
    end else if (SHARED > 0) begin : genSingle
      assign sharedGrant = reset_n ? sharedReq : '0;
    end else begin : genNoShared
      assign sharedGrant = '0;
    end
  endgenerate

  // Mux the winning core's address and data onto the shared write port.
  always_comb begin
    sharedWe    = 1'b0;
    sharedWaddr = '0;
    sharedWdata = '0;
    for (int c = 0; c < CORES; c++) begin
      if (sharedGrant[c]) begin
        sharedWe    = 1'b1;
        sharedWaddr = rfBus.write_address[c];
        sharedWdata = rfBus.write_data[c];
      end
    end
  end

  // Shared bank storage, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SH_N; s++) begin
        sharedBank[s] <= '0;
      end
    end else if (sharedWe) begin
      for (int s = 0; s < SH_N; s++) begin
        if (int'(sharedWaddr) == SHARED_BASE + s) begin
          sharedBank[s] <= sharedWdata;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CORES; gi++) begin : genCore
      logic [WIDTH-1:0] bank [DEPTH];
      logic [AW-1:0]    wAddr;
      logic             wEn;
      logic             wShared;
      logic [AW-1:0]    rdAddr [2];
      logic [WIDTH-1:0] rdVal  [2];

      assign wAddr   = rfBus.write_address[gi];
      assign wEn     = rfBus.write_enable[gi];
      assign wShared = is_shared(int'(wAddr), DEPTH, SHARED);

      assign sharedReq[gi] = wEn && wShared;
      // Writes to the zero register are granted but never stored.
      assign privWe[gi]    = reset_n && wEn && !wShared && (int'(wAddr) != ZERO_REG);
      assign rfBus.write_grant[gi] = reset_n && (wShared ? sharedGrant[gi] : wEn);

      // Private bank storage, cleared asynchronously.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int a = 0; a < DEPTH; a++) begin
            bank[a] <= '0;
          end
        end else if (privWe[gi]) begin
          bank[wAddr] <= rfBus.write_data[gi];
        end
      end

      assign rdAddr[0] = rfBus.read_address_1[gi];
      assign rdAddr[1] = rfBus.read_address_2[gi];

      // Combinational read of both ports: zero, shared window, or own bank.
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          rdVal[p] = '0;
          if (int'(rdAddr[p]) == ZERO_REG) begin
            rdVal[p] = '0;
          end else if (is_shared(int'(rdAddr[p]), DEPTH, SHARED)) begin
            for (int s = 0; s < SH_N; s++) begin
              if (int'(rdAddr[p]) == SHARED_BASE + s) begin
                rdVal[p] = sharedBank[s];
              end
            end
`ifdef REGISTERFILE_BYPASS_EN
            if (sharedWe && (sharedWaddr == rdAddr[p])) begin
              rdVal[p] = sharedWdata;
            end
`endif
          end else begin
            rdVal[p] = bank[rdAddr[p]];
`ifdef REGISTERFILE_BYPASS_EN
            if (privWe[gi] && (wAddr == rdAddr[p])) begin
              rdVal[p] = rfBus.write_data[gi];
            end
`endif
          end
        end
      end

      assign rfBus.read_data_1[gi] = rdVal[0];
      assign rfBus.read_data_2[gi] = rdVal[1];
    end
  endgenerate

endmodule

// File: tb/tb_registerfile_mc.sv
// Testbench for registerfile_mc: a 4-core instance checked every cycle against
// an array-based model, plus a 1-core instance checked with literal values.
module tb_registerfile_mc;

  localparam int C = 4;
  localparam int W = 32;
  localparam int D = 32;
  localparam int S = 4;

`ifdef REGISTERFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  registerfile_mc_if #(.CORES(C), .WIDTH(W), .DEPTH(D)) bus4 ();
  registerfile_mc_if #(.CORES(1), .WIDTH(W), .DEPTH(D)) bus1 ();

  registerfile_mc #(.CORES(C), .WIDTH(W), .DEPTH(D), .SHARED(S)) dut4 (
    .clk     (clk),
    .reset_n (resetN),
    .rfBus   (bus4)
  );

  registerfile_mc #(.CORES(1), .WIDTH(W), .DEPTH(D), .SHARED(S)) dut1 (
    .clk     (clk),
    .reset_n (resetN),
    .rfBus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] expOrd [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (4-core instance) ----------------
  bit [31:0] mPriv [C][D];
  bit [31:0] mShr  [D];
  int        mPtr;

  function automatic bit mIsShr(input int a);
    return a >= D - S;
  endfunction

  function automatic bit mWants(input int c);
    return bus4.write_enable[c] && mIsShr(int'(bus4.write_address[c]));
  endfunction

  // Shared-write winner this cycle, or -1.
  function automatic int mWinner();
    for (int k = 0; k < C; k++) begin
      if (mWants((mPtr + k) % C)) return (mPtr + k) % C;
    end
    return -1;
  endfunction

  function automatic bit mGrant(input int c);
    if (!resetN) return 1'b0;
    if (mWants(c)) return mWinner() == c;
    return bus4.write_enable[c];
  endfunction

  function automatic logic [31:0] mRead(input int c, input int a);
    int w;
    if (a == 0) return 32'h0;
    if (mIsShr(a)) begin
      w = mWinner();
      if (BYP && resetN && w >= 0 && int'(bus4.write_address[w]) == a) return bus4.write_data[w];
      return mShr[a];
    end
    if (BYP && resetN && bus4.write_enable[c] && int'(bus4.write_address[c]) == a) return bus4.write_data[c];
    return mPriv[c][a];
  endfunction

  always @(posedge clk or negedge resetN) begin
    int w;
    int a;
    if (!resetN) begin
      for (int c = 0; c < C; c++) for (int r = 0; r < D; r++) mPriv[c][r] = '0;
      for (int r = 0; r < D; r++) mShr[r] = '0;
      mPtr = 0;
    end else begin
      w = mWinner();
      for (int c = 0; c < C; c++) begin
        a = int'(bus4.write_address[c]);
        if (bus4.write_enable[c] && !mIsShr(a) && a != 0) mPriv[c][a] = bus4.write_data[c];
      end
      if (w >= 0) begin
        mShr[int'(bus4.write_address[w])] = bus4.write_data[w];
        mPtr = (w + 1) % C;
      end
    end
  end

  // Every-cycle comparison of the 4-core instance against the model.
  always @(negedge clk) begin
    for (int c = 0; c < C; c++) begin
      check($sformatf("model c%0d grant", c), 32'(bus4.write_grant[c]), 32'(mGrant(c)));
      check($sformatf("model c%0d rd1", c), bus4.read_data_1[c], mRead(c, int'(bus4.read_address_1[c])));
      check($sformatf("model c%0d rd2", c), bus4.read_data_2[c], mRead(c, int'(bus4.read_address_2[c])));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clearIn();
    bus4.write_enable   = '0;
    bus4.write_address  = '0;
    bus4.write_data     = '0;
    bus4.read_address_1 = '0;
    bus4.read_address_2 = '0;
    bus1.write_enable   = '0;
    bus1.write_address  = '0;
    bus1.write_data     = '0;
    bus1.read_address_1 = '0;
    bus1.read_address_2 = '0;
  endtask

  task automatic wr(input int c, input int a, input logic [31:0] d);
    bus4.write_enable[c]  = 1'b1;
    bus4.write_address[c] = 5'(a);
    bus4.write_data[c]    = d;
  endtask

  task automatic rd(input int c, input int a1, input int a2);
    bus4.read_address_1[c] = 5'(a1);
    bus4.read_address_2[c] = 5'(a2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold shared requests until granted, checking the grant order in expOrd.
  task automatic arbSeq(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s grant step%0d", tag, k), 32'(bus4.write_grant), 32'(expOrd[k]));
      step();
      for (int c = 0; c < C; c++) if (expOrd[k][c]) bus4.write_enable[c] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetN = 1'b0;
    clearIn();
    // Requests during reset are not granted
    wr(0, 5, 32'h55);
    bus1.write_enable  = 1'b1;
    bus1.write_address = 5'd3;
    @(negedge clk);
    check("reset grant4", 32'(bus4.write_grant), 32'h0);
    check("reset grant1", 32'(bus1.write_grant), 32'h0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    clearIn();

    // Single core: r15 write, then disabled write leaves it alone
    bus1.write_enable   = 1'b1;
    bus1.write_address  = 5'd15;
    bus1.write_data     = 32'h15;
    bus1.read_address_1 = 5'd15;
    bus1.read_address_2 = 5'd31;
    @(negedge clk);
    check("1c wr15 grant", 32'(bus1.write_grant), 32'h1);
    check("1c r15 same cycle", bus1.read_data_1[0], BYP ? 32'h15 : 32'h0);
    step();
    bus1.write_enable = 1'b0;
    bus1.write_data   = 32'h1F;
    @(negedge clk);
    check("1c r15 after edge", bus1.read_data_1[0], 32'h15);
    check("1c idle grant", 32'(bus1.write_grant), 32'h0);
    step();
    bus1.write_enable  = 1'b1;
    bus1.write_address = 5'd31;
    bus1.write_data    = 32'h31;
    @(negedge clk);
    check("1c r15 held", bus1.read_data_1[0], 32'h15);
    check("1c shared grant", 32'(bus1.write_grant), 32'h1);
    step();
    bus1.write_enable = 1'b0;
    @(negedge clk);
    check("1c r31", bus1.read_data_2[0], 32'h31);
    step();
    clearIn();

    // Four cores write private r5 together
    for (int c = 0; c < C; c++) begin
      wr(c, 5, 32'h10 + 32'(c));
      rd(c, 5, 0);
    end
    @(negedge clk);
    check("private r5 grants", 32'(bus4.write_grant), 32'hF);
    step();
    bus4.write_enable = '0;
    @(negedge clk);
    for (int c = 0; c < C; c++) check($sformatf("private r5 c%0d", c), bus4.read_data_1[c], 32'h10 + 32'(c));
    // r0 writes are granted and discarded
    for (int c = 0; c < C; c++) begin
      wr(c, 0, 32'hFF);
      rd(c, 0, 5);
    end
    step();
    bus4.write_enable = '0;
    @(negedge clk);
    for (int c = 0; c < C; c++) begin
      check($sformatf("r0 c%0d", c), bus4.read_data_1[c], 32'h0);
      check($sformatf("r5 kept c%0d", c), bus4.read_data_2[c], 32'h10 + 32'(c));
    end
    step();
    clearIn();

    // Shared contention on r30 from cores 0,2,3
    wr(0, 30, 32'hA0);
    wr(2, 30, 32'hA2);
    wr(3, 30, 32'hA3);
    for (int c = 0; c < C; c++) rd(c, 30, 5);
    expOrd[0] = 4'b0001;
    expOrd[1] = 4'b0100;
    expOrd[2] = 4'b1000;
    arbSeq("r30", 3);
    @(negedge clk);
    for (int c = 0; c < C; c++) check($sformatf("r30 final c%0d", c), bus4.read_data_1[c], 32'hA3);

    // Pointer wrapped to 0: core 1 before core 3
    step();
    clearIn();
    wr(1, 29, 32'hB1);
    wr(3, 29, 32'hB3);
    for (int c = 0; c < C; c++) rd(c, 29, 30);
    expOrd[0] = 4'b0010;
    expOrd[1] = 4'b1000;
    arbSeq("wrap", 2);
    @(negedge clk);
    for (int c = 0; c < C; c++) check($sformatf("r29 final c%0d", c), bus4.read_data_1[c], 32'hB3);

    // Move pointer to 2, then reset mid-cycle with writes pending
    step();
    clearIn();
    wr(1, 28, 32'hC1);
    @(negedge clk);
    check("pre-reset c1 grant", 32'(bus4.write_grant), 32'h2);
    step();
    clearIn();
    for (int c = 0; c < C; c++) rd(c, 5, 30);
    wr(2, 31, 32'hDD);
    wr(0, 6, 32'h66);
    #2;
    resetN = 1'b0;
    #1;
    for (int c = 0; c < C; c++) begin
      check($sformatf("mid reset rd1 c%0d", c), bus4.read_data_1[c], 32'h0);
      check($sformatf("mid reset rd2 c%0d", c), bus4.read_data_2[c], 32'h0);
    end
    check("mid reset grants", 32'(bus4.write_grant), 32'h0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    clearIn();
    // Pointer restarted at 0: core 1 wins over core 2
    wr(1, 31, 32'hE1);
    wr(2, 31, 32'hE2);
    expOrd[0] = 4'b0010;
    expOrd[1] = 4'b0100;
    arbSeq("post reset", 2);
    clearIn();
    for (int c = 0; c < C; c++) rd(c, 31, 5);
    @(negedge clk);
    for (int c = 0; c < C; c++) begin
      check($sformatf("r31 c%0d", c), bus4.read_data_1[c], 32'hE2);
      check($sformatf("r5 cleared c%0d", c), bus4.read_data_2[c], 32'h0);
    end
    rd(0, 6, 28);
    #1;
    check("dropped r6", bus4.read_data_1[0], 32'h0);
    check("cleared r28", bus4.read_data_2[0], 32'h0);
    step();
    clearIn();

    // Same-cycle read of an in-flight private write
    wr(1, 7, 32'hBEEF);
    rd(1, 7, 0);
    rd(0, 7, 0);
    @(negedge clk);
    check("c1 r7 same cycle", bus4.read_data_1[1], BYP ? 32'hBEEF : 32'h0);
    check("c0 r7 other bank", bus4.read_data_1[0], 32'h0);
    step();
    bus4.write_enable = '0;
    @(negedge clk);
    check("c1 r7 after edge", bus4.read_data_1[1], 32'hBEEF);
    check("c0 r7 untouched", bus4.read_data_1[0], 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
